// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// FSM state encoding and the count-width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    int n;
    n = 1;
    while ((1 << n) < w) n++;
    return n;
  endfunction

endpackage

// File: rtl/fa_nand.sv
// One-bit full adder built purely from two-input NAND gates.
// Shared by the serial controller for every bit position.
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire n1, n2, n3, x1;
  wire n4, n5, n6;

  // first stage forms a^b, second stage folds in the carry
  nand g1 (n1, a, b);
  nand g2 (n2, a, n1);
  nand g3 (n3, b, n1);
  nand g4 (x1, n2, n3);
  nand g5 (n4, x1, ci);
  nand g6 (n5, x1, n4);
  nand g7 (n6, ci, n4);
  nand g8 (s, n5, n6);
  nand g9 (co, n4, n1);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract, LSB first, one shared full-adder cell.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow port ovf.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             carry;
  logic             co_r;
  logic             valid;
  logic             sum;
  logic             co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_r;
`endif

  fa_nand u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      co_r  <= 1'b0;
      valid <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // subtract as a + ~b + 1
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= {sum, acc[WIDTH-1:1]};
          carry <= co;
          count <= count + CW'(1);
          if (count == LAST) begin
            count <= '0;
            co_r  <= co;
            valid <= 1'b1;
            state <= DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_r <= carry ^ co;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n & (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = valid;
  assign result    = acc;
  assign cout      = co_r;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH=8).
// ovf is checked only when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_bp = 0;
  logic prev_ov = 1'b0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int r;
    logic c;
    logic v;
    logic [W-1:0] q;
    if (s) begin
      r = int'(x) - int'(y);
      c = (x >= y);
    end else begin
      r = int'(x) + int'(y);
      c = (r > ((1 << W) - 1));
    end
    q = r[W-1:0];
    if (s) v = (x[W-1] != y[W-1]) && (q[W-1] != x[W-1]);
    else v = (x[W-1] == y[W-1]) && (q[W-1] != x[W-1]);
    return {q, c, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL latency actual=unexpected_valid required=no_valid");
        end else begin
          chk("latency", cyc - acc_q.pop_front(), W);
        end
      end
      if (out_valid) chk("in_ready_done", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", result);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e[W+1:2]);
          chk("cout", cout, e[1]);
`ifdef SERIAL_ADDSUB_OVF_EN
          chk("ovf", ovf, e[0]);
`endif
        end
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0b required=1", in_ready);
      return;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    @(posedge clk);
    #1;
    exp_q.push_back(model(x, y, s));
    acc_q.push_back(cyc);
    // scramble operands after acceptance; they must not matter
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(8'h80);
      3: return W'(8'h7F);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_ovf"}, ovf, 0);
`endif
  endtask

  initial begin
    logic [W+1:0] e;
    int n;

    #3;
    check_reset_state("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1);

    send(8'h5A, 8'h3C, 1'b0);
    send(8'h10, 8'h20, 1'b1);
    send(8'h80, 8'h01, 1'b1);
    send(8'hFF, 8'h01, 1'b0);
    drain();

    out_ready = 1'b0;
    send(8'hC3, 8'h2D, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_done", out_valid, 1);
    e = model(8'hC3, 8'h2D, 1'b0);
    repeat (5) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, e[W+1:2]);
      chk("bp_cout", cout, e[1]);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_back_idle", busy, 0);
    drain();

    send(8'h44, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("abort_release_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 0);
    send(8'h01, 8'h01, 1'b0);
    drain();

    rand_bp = 1;
    repeat (40) send(pick(), pick(), 1'($urandom));
    rand_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
